// File: rtl/frame_tx_streamer.sv
// Streams one frame buffer out as SOF, per-pixel channel bytes, checksum and EOF
// into a byte-wide TX FIFO, with stall, abort and single-channel support.
module frame_tx_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH = 3,
  parameter int PIXELS = 176*240,
  parameter int ADDR_WIDTH = $clog2(PIXELS),
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] EOF_BYTE = 8'h55
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  input  logic mode_single,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic rd_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
  input  logic tx_fifo_full,
  output logic push_en,
  output logic [DATA_WIDTH-1:0] push_data,
  output logic busy,
  output logic pixel_done,
  output logic frame_done,
  output logic frame_aborted
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0] NCH = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0] TOP_CH = CH_W'(NUM_CH-1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(PIXELS-1);

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_FETCH, S_WAIT,
    S_SEND, S_CSUM, S_EOF, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [CH_W-1:0] sel_q, sel_d;
  logic single_q, single_d;
  logic [NUM_CH*DATA_WIDTH-1:0] pix_q, pix_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic push_en_q, push_en_d;
  logic [DATA_WIDTH-1:0] push_data_q, push_data_d;
  logic rd_en_q, rd_en_d;
  logic busy_q, busy_d;
  logic pixel_done_q, pixel_done_d;
  logic frame_done_q, frame_done_d;
  logic aborted_q, aborted_d;

  logic [DATA_WIDTH-1:0] cur_byte;
  logic last_ch;
  logic can_push;

  always_comb begin
    cur_byte = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) cur_byte = pix_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign last_ch  = single_q || (ch_q == '0);
  assign can_push = !tx_fifo_full;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    ch_d         = ch_q;
    sel_d        = sel_q;
    single_d     = single_q;
    pix_d        = pix_q;
    csum_d       = csum_q;
    push_en_d    = 1'b0;
    push_data_d  = push_data_q;
    pixel_done_d = 1'b0;
    frame_done_d = 1'b0;
    aborted_d    = 1'b0;
    if (abort && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      addr_d    = '0;
      aborted_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (start) begin
          single_d = mode_single;
          sel_d    = ({1'b0, ch_sel} < NCH) ? ch_sel : '0;
          csum_d   = '0;
          addr_d   = '0;
          state_d  = S_SOF;
        end
        S_SOF: if (can_push) begin
          push_en_d   = 1'b1;
          push_data_d = SOF_BYTE;
          state_d     = S_FETCH;
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          pix_d   = rd_data;
          ch_d    = single_q ? sel_q : TOP_CH;
          state_d = S_SEND;
        end
        S_SEND: if (can_push) begin
          push_en_d   = 1'b1;
          push_data_d = cur_byte;
          csum_d      = csum_q + cur_byte;
          if (last_ch) begin
            pixel_done_d = 1'b1;
            if (addr_q == LAST) begin
              addr_d  = '0;
              state_d = S_CSUM;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_FETCH;
            end
          end else begin
            ch_d = ch_q - 1'b1;
          end
        end
        S_CSUM: if (can_push) begin
          push_en_d   = 1'b1;
          push_data_d = csum_q;
          state_d     = S_EOF;
        end
        S_EOF: if (can_push) begin
          push_en_d   = 1'b1;
          push_data_d = EOF_BYTE;
          state_d     = S_DONE;
        end
        S_DONE: begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Strobes follow the state being entered so they line up with it
    rd_en_d = (state_d == S_FETCH);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      ch_q         <= '0;
      sel_q        <= '0;
      single_q     <= 1'b0;
      pix_q        <= '0;
      csum_q       <= '0;
      push_en_q    <= 1'b0;
      push_data_q  <= '0;
      rd_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      pixel_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      ch_q         <= ch_d;
      sel_q        <= sel_d;
      single_q     <= single_d;
      pix_q        <= pix_d;
      csum_q       <= csum_d;
      push_en_q    <= push_en_d;
      push_data_q  <= push_data_d;
      rd_en_q      <= rd_en_d;
      busy_q       <= busy_d;
      pixel_done_q <= pixel_done_d;
      frame_done_q <= frame_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign rd_addr       = addr_q;
  assign rd_en         = rd_en_q;
  assign push_en       = push_en_q;
  assign push_data     = push_data_q;
  assign busy          = busy_q;
  assign pixel_done    = pixel_done_q;
  assign frame_done    = frame_done_q;
  assign frame_aborted = aborted_q;

endmodule

// File: tb/tb_frame_tx_streamer.sv
// Bench for frame_tx_streamer with a 4-pixel frame buffer model and
// a byte scoreboard fed from a reference frame builder.
module tb_frame_tx_streamer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic mode_single = 1'b0;
  logic [1:0] ch_sel = 2'd0;
  logic [1:0] rd_addr;
  logic rd_en;
  logic [23:0] rd_data = '0;
  logic tx_fifo_full = 1'b0;
  logic push_en;
  logic [7:0] push_data;
  logic busy, pixel_done, frame_done, frame_aborted;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  frame_tx_streamer #(.PIXELS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .mode_single(mode_single), .ch_sel(ch_sel),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .tx_fifo_full(tx_fifo_full), .push_en(push_en),
    .push_data(push_data), .busy(busy), .pixel_done(pixel_done),
    .frame_done(frame_done), .frame_aborted(frame_aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en)
      rd_data <= {8'(rd_addr) + 8'd1, 8'(rd_addr) + 8'd2,
                  8'(rd_addr) + 8'd3};

  task automatic push_frame(input bit single, input int sel);
    logic [7:0] sum = 8'h00;
    logic [7:0] b;
    int k0 = (sel > 2) ? 0 : sel;
    exp_q.push_back(8'hAA);
    for (int a = 0; a < 4; a++)
      for (int k = 2; k >= 0; k--)
        if (!single || k == k0) begin
          b = 8'(a + 3 - k);
          exp_q.push_back(b);
          sum = sum + b;
        end
    exp_q.push_back(sum);
    exp_q.push_back(8'h55);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // kind: 0 run to want_fd frames, 1 abort / 2 reset after trig_at pushes
  task automatic drain(input int max_cyc, input bit rnd,
                       input int want_fd, input int trig_at,
                       input int kind, output int np, output int npd,
                       output int nfd, output int nfa);
    bit prev_full;
    bit fired = 1'b0;
    int hold = 0;
    int after = -1;
    logic [7:0] e;
    np = 0; npd = 0; nfd = 0; nfa = 0;
    prev_full = tx_fifo_full;
    if (rnd) begin
      tx_fifo_full = 1'b1;
      hold = 20;
    end
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (push_en) begin
        np++;
        checks++;
        if (prev_full) begin
          failures++;
          $display("FAIL push_after_full: push_en=1 required 0");
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL extra_push: got %h required none", push_data);
        end else begin
          e = exp_q.pop_front();
          if (push_data !== e) begin
            failures++;
            $display("FAIL byte%0d: got %h required %h",
                     np, push_data, e);
          end
        end
      end
      if (pixel_done) npd++;
      if (frame_done) nfd++;
      if (frame_aborted) nfa++;
      if (fired) after++;
      if (fired && after == 0 && kind == 1) begin
        checks++;
        if ({frame_aborted, busy, push_en} !== 3'b100) begin
          failures++;
          $display("FAIL abort_state: aborted/busy/push=%b required 100",
                   {frame_aborted, busy, push_en});
        end
      end
      if (fired && after == 0 && kind == 2) begin
        checks++;
        if ({rd_addr, rd_en, push_en, push_data, busy, pixel_done,
             frame_done, frame_aborted} !== '0) begin
          failures++;
          $display("FAIL reset_outs: addr=%0d rd=%b push=%b data=%h busy=%b",
                   rd_addr, rd_en, push_en, push_data, busy);
        end
      end
      if (kind != 0 && !fired && np == trig_at) begin
        fired = 1'b1;
        if (kind == 1) abort = 1'b1;
        else reset = 1'b1;
      end else begin
        abort = 1'b0;
        reset = 1'b0;
      end
      if (kind == 0 && nfd >= want_fd) break;
      if (kind != 0 && after >= 10) break;
      if (rnd) begin
        if (hold > 0) begin
          hold--;
          tx_fifo_full = 1'b1;
        end else begin
          int r = int'($urandom_range(0, 9));
          if (r == 0) begin
            tx_fifo_full = 1'b1;
            hold = int'($urandom_range(0, 19));
          end else tx_fifo_full = (r < 4);
        end
      end
      prev_full = tx_fifo_full;
    end
    tx_fifo_full = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit single,
                           input int sel, input bit rnd);
    int np, npd, nfd, nfa;
    int len = single ? 7 : 15;
    mode_single = single;
    ch_sel = 2'(sel);
    push_frame(single, sel);
    pulse_start();
    mode_single = ~single;
    ch_sel = 2'd2;
    drain(3000, rnd, 1, 0, 0, np, npd, nfd, nfa);
    checks++;
    if (nfd != 1 || np != len || npd != 4) begin
      failures++;
      $display("FAIL %s_counts: frames=%0d pushes=%0d pix=%0d required 1/%0d/4",
               tag, nfd, np, npd, len);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_left: %0d bytes unsent required 0", tag, exp_q.size());
    end
    checks++;
    if (busy !== 1'b0 || rd_addr !== 2'd0) begin
      failures++;
      $display("FAIL %s_end: busy=%b addr=%0d required 0/0",
               tag, busy, rd_addr);
    end
    exp_q.delete();
    mode_single = 1'b0;
    ch_sel = 2'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_addr, rd_en, push_en, push_data, busy, pixel_done,
         frame_done, frame_aborted} !== '0) begin
      failures++;
      $display("FAIL reset_vals: addr=%0d rd=%b push=%b data=%h busy=%b",
               rd_addr, rd_en, push_en, push_data, busy);
    end
    reset = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (frame_aborted !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_abort: aborted=%b busy=%b required 0/0",
               frame_aborted, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_full();
    run_frame("full", 1'b0, 0, 1'b0);
  endtask

  task automatic test_single();
    run_frame("single1", 1'b1, 1, 1'b0);
    run_frame("single_oob", 1'b1, 3, 1'b0);
  endtask

  task automatic test_stall();
    run_frame("stall", 1'b0, 0, 1'b1);
  endtask

  task automatic test_abort();
    int np, npd, nfd, nfa;
    exp_q.push_back(8'hAA);
    for (int i = 1; i <= 3; i++) exp_q.push_back(8'(i));
    pulse_start();
    drain(200, 1'b0, 1, 4, 1, np, npd, nfd, nfa);
    checks++;
    if (np != 4 || nfa != 1 || nfd != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort: pushes=%0d aborted=%0d done=%0d busy=%b req 4/1/0/0",
               np, nfa, nfd, busy);
    end
    exp_q.delete();
    run_frame("after_abort", 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int np, npd, nfd, nfa;
    push_frame(1'b0, 0);
    pulse_start();
    drain(200, 1'b0, 1, 5, 2, np, npd, nfd, nfa);
    checks++;
    if (np != 5 || nfd != 0 || nfa != 0) begin
      failures++;
      $display("FAIL reset_mid: pushes=%0d done=%0d aborted=%0d required 5/0/0",
               np, nfd, nfa);
    end
    exp_q.delete();
    run_frame("after_reset", 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int np, npd, nfd, nfa;
    push_frame(1'b0, 0);
    push_frame(1'b0, 0);
    start = 1'b1;
    @(negedge clk);
    drain(400, 1'b0, 2, 0, 0, np, npd, nfd, nfa);
    start = 1'b0;
    checks++;
    if (nfd != 2 || np != 30 || npd != 8 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b: frames=%0d pushes=%0d pix=%0d left=%0d req 2/30/8/0",
               nfd, np, npd, exp_q.size());
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b required 0", busy);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_full();
    test_single();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
